// File: rtl/ram_req_arbiter_pkg.sv
// ram_req_arbiter_pkg: shared RAM command encoding, sizes and arbiter state enum
package ram_req_arbiter_pkg;
  localparam int MEM_WIDTH = 8;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} control_e;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} arb_state_e;
endpackage

// File: rtl/ram_req_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick (req, last -> one-hot win)
module rr_arb2
  import ram_req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  always_comb win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter: 2-master round-robin front-end sequencing word requests into RAM commands; RAM_ARB_TIMEOUT_EN adds read timeout
module ram_req_arbiter
  import ram_req_arbiter_pkg::*;
#(
  parameter int MEM_WIDTH  = ram_req_arbiter_pkg::MEM_WIDTH,
  parameter int ADDR_SIZE  = ram_req_arbiter_pkg::ADDR_SIZE,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req,
  input  logic [1:0]                req_we,
  input  logic [1:0][ADDR_SIZE-1:0] req_addr,
  input  logic [1:0][MEM_WIDTH-1:0] req_wdata,
  output logic [1:0]                gnt,
  output logic [1:0]                done,
  output logic [MEM_WIDTH-1:0]      rdata,
  output logic                      err,
  output logic [MEM_WIDTH+1:0]      rx_data,
  output logic                      rx_valid,
  input  logic                      tx_valid,
  input  logic [MEM_WIDTH-1:0]      dout
);
  if (ADDR_SIZE > MEM_WIDTH || RD_TIMEOUT < 1) begin : g_bad_cfg
    $error("ram_req_arbiter: ADDR_SIZE must be <= MEM_WIDTH and RD_TIMEOUT >= 1");
  end
  arb_state_e state_q, state_d;
  logic we_q, we_d, idx_q, idx_d, last_q, last_d, err_q, err_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] gnt_q, gnt_d, done_q, done_d, win;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  rr_arb2 u_arb (.req(req), .last(last_q), .win(win));
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (|req && !(|done_q)) begin
        we_d    = req_we[win[1]];
        addr_d  = req_addr[win[1]];
        wdata_d = req_wdata[win[1]];
        idx_d   = win[1];
        last_d  = win[1];
        gnt_d   = win;
        state_d = ADDR;
      end
      ADDR: state_d = DATA;
      DATA: begin
        state_d = we_q ? IDLE : WAIT;
        done_d  = we_q ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      default: if (tx_valid) begin
        rdata_d = dout;
        done_d  = idx_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
`ifdef RAM_ARB_TIMEOUT_EN
      else if (cnt_q + CW'(1) == CW'(RD_TIMEOUT)) begin
        done_d  = idx_q ? 2'b10 : 2'b01;
        err_d   = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q + CW'(1);
`endif
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_q   <= cnt_d;
`endif
  end
  always_comb begin
    rx_valid = (state_q == ADDR) || (state_q == DATA);
    rx_data  = (state_q == ADDR) ? {we_q ? WR_ADDR : RD_ADDR, MEM_WIDTH'(addr_q)} :
               (state_q == DATA) ? {we_q ? WR_DATA : RD_DATA, we_q ? wdata_q : {MEM_WIDTH{1'b0}}} : '0;
  end
  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb_ram_req_arbiter: directed self-checking bench for ram_req_arbiter
module tb_ram_req_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, err, rx_valid;
  logic [1:0] req = '0, req_we = '0, gnt, done;
  logic [1:0][7:0] req_addr = '0, req_wdata = '0;
  logic [7:0] rdata, dout = '0;
  logic [9:0] rx_data;
  int n_cmp = 0, n_err = 0;
  ram_req_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_valid(tx_valid), .dout(dout)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL rst_done: got %b want 00", done); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL rst_rx_data: got %h want 000", rx_data); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_single_write_stale;
    req_we[0] = 1'b1; req_addr[0] = 8'h12; req_wdata[0] = 8'hA5; req[0] = 1'b1;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL wr_gnt: got %b want 01", gnt); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL wr_addr_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 10'h012) begin n_err++; $display("FAIL wr_addr_word: got %h want 012", rx_data); end
    tick;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL wr_gnt_pulse: got %b want 00", gnt); end
    n_cmp++; if (rx_data !== 10'h1A5) begin n_err++; $display("FAIL wr_data_word: got %h want 1a5", rx_data); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL wr_done_early: got %b want 00", done); end
    tick;
    n_cmp++; if (done !== 2'b01) begin n_err++; $display("FAIL wr_done: got %b want 01", done); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL wr_idle_valid: got %b want 0", rx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wr_err: got %b want 0", err); end
    tick;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL stale_gnt: got %b want 00", gnt); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL stale_valid: got %b want 0", rx_valid); end
    req[0] = 1'b0;
    tick;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL stale_gnt2: got %b want 00", gnt); end
  endtask
  task automatic test_ignored_tx;
    tx_valid = 1'b1; dout = 8'h5A;
    tick;
    tx_valid = 1'b0;
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL idle_tx_done: got %b want 00", done); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL idle_tx_rdata: got %h want 00", rdata); end
  endtask
  task automatic test_read_back;
    req_we[1] = 1'b0; req_addr[1] = 8'h12; req[1] = 1'b1;
    tick;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rd_gnt: got %b want 10", gnt); end
    n_cmp++; if (rx_data !== 10'h212) begin n_err++; $display("FAIL rd_addr_word: got %h want 212", rx_data); end
    tick;
    n_cmp++; if (rx_data !== 10'h300) begin n_err++; $display("FAIL rd_data_word: got %h want 300", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rd_data_valid: got %b want 1", rx_valid); end
    tick;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rd_wait_valid: got %b want 0", rx_valid); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL rd_wait_done: got %b want 00", done); end
    tx_valid = 1'b1; dout = 8'hA5;
    tick;
    tx_valid = 1'b0; dout = 8'h00;
    n_cmp++; if (done !== 2'b10) begin n_err++; $display("FAIL rd_done: got %b want 10", done); end
    n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL rd_rdata: got %h want a5", rdata); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", err); end
    req[1] = 1'b0;
    tick;
  endtask
  task automatic test_wait;
    req_we[0] = 1'b0; req_addr[0] = 8'h30; req[0] = 1'b1;
    tick;
    tick;
`ifdef RAM_ARB_TIMEOUT_EN
    for (int c = 3; c <= 6; c++) begin
      tick;
      n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL to_done_early c%0d: got %b want 00", c, done); end
    end
    tick;
    n_cmp++; if (done !== 2'b01) begin n_err++; $display("FAIL to_done: got %b want 01", done); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", err); end
    n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL to_rdata: got %h want a5", rdata); end
`else
    for (int c = 3; c <= 12; c++) begin
      tick;
      n_cmp++; if (done !== 2'b00 || err !== 1'b0) begin n_err++; $display("FAIL wait_block c%0d: got done=%b err=%b want 00/0", c, done, err); end
    end
    tx_valid = 1'b1; dout = 8'h3C;
    tick;
    tx_valid = 1'b0; dout = 8'h00;
    n_cmp++; if (done !== 2'b01) begin n_err++; $display("FAIL wait_done: got %b want 01", done); end
    n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL wait_rdata: got %h want 3c", rdata); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL wait_err: got %b want 0", err); end
`endif
    req[0] = 1'b0;
    tick;
  endtask
  task automatic test_reset_mid_read;
    req_we[1] = 1'b0; req_addr[1] = 8'h44; req[1] = 1'b1;
    tick;
    tick;
    n_cmp++; if (rx_data !== 10'h300) begin n_err++; $display("FAIL mr_data_word: got %h want 300", rx_data); end
    rst_n = 1'b0;
    tick;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL mr_rx_data: got %h want 000", rx_data); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL mr_done: got %b want 00", done); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL mr_rdata: got %h want 00", rdata); end
    rst_n = 1'b1; req[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_cmp++; if (done !== 2'b00 || gnt !== 2'b00) begin n_err++; $display("FAIL mr_abandon c%0d: got done=%b gnt=%b want 00/00", c, done, gnt); end
    end
  endtask
  task automatic test_tie_alternation;
    logic [1:0] eg [11] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [1:0] ed [11] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [9:0] er [11] = '{10'h020, 10'h111, 10'h000, 10'h000, 10'h021, 10'h122, 10'h000, 10'h000, 10'h020, 10'h111, 10'h000};
    req_we = 2'b11;
    req_addr[0] = 8'h20; req_wdata[0] = 8'h11;
    req_addr[1] = 8'h21; req_wdata[1] = 8'h22;
    req = 2'b11;
    for (int c = 1; c <= 11; c++) begin
      tick;
      n_cmp++; if (gnt !== eg[c-1]) begin n_err++; $display("FAIL tie_gnt c%0d: got %b want %b", c, gnt, eg[c-1]); end
      n_cmp++; if (done !== ed[c-1]) begin n_err++; $display("FAIL tie_done c%0d: got %b want %b", c, done, ed[c-1]); end
      n_cmp++; if (rx_data !== er[c-1]) begin n_err++; $display("FAIL tie_rx_data c%0d: got %h want %h", c, rx_data, er[c-1]); end
    end
    req = 2'b00;
    tick;
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL tie_end_gnt: got %b want 00", gnt); end
  endtask
  initial begin
    test_reset;
    test_single_write_stale;
    test_ignored_tx;
    test_read_back;
    test_wait;
    test_reset_mid_read;
    test_tie_alternation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
